// File: rtl/bus_arbiter.sv
// bus_arbiter: five-way DRAM/bus arbiter with fixed priority, a blitter/GPU
// rotating slot, urgent-refresh promotion, tenure limit and turnaround gap.
//
// Ports:
//   sys_clk   system clock; all state is registered on its rising edge
//   resetl    synchronous active-low reset
//   clk       bus clock, sampled; a 0->1 sample is a "tick"
//   req[4:0]  0=refresh 1=object proc 2=blitter 3=GPU 4=CPU
//   rfull     refresh backlog full; lifts req[0] to top priority
//   cyc_done  current bus cycle completes on this tick
//   gnt[4:0]  registered one-hot grant
//   ack[4:0]  grant qualified by cyc_done on a tick cycle
//   owner     index of grantee, 7 when no grant
//   busy      high while a grant is held
module bus_arbiter #(
  parameter int TURN_TICKS = 1,
  parameter int HOLD_MAX   = 16
) (
  input  logic       sys_clk,
  input  logic       resetl,
  input  logic       clk,
  input  logic [4:0] req,
  input  logic       rfull,
  input  logic       cyc_done,
  output logic [4:0] gnt,
  output logic [4:0] ack,
  output logic [2:0] owner,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t      st, st_n;
  logic        clk_q;
  logic        tick;
  logic [4:0]  gnt_n;
  logic [2:0]  owner_n;
  logic [2:0]  win;
  logic [5:0]  hc, hc_n;
  logic [1:0]  tc, tc_n;
  logic        rr, rr_n;
  logic [6:0]  hc_inc;
  logic        others;
  logic        held;
  logic        limit;

  assign tick = clk & ~clk_q;
  assign busy = (st == GRANT);
  assign ack  = gnt & {5{cyc_done & tick}};

  // hc+1 is taken one bit wider so the compare
  // still works once hc has saturated at 63.
  assign hc_inc = {1'b0, hc} + 7'd1;
  assign limit  = (hc_inc >= 7'(HOLD_MAX));
  assign others = |(req & ~gnt);
  assign held   = |(req & gnt);

  // rr=0 prefers the blitter, rr=1 the GPU.
  always_comb begin
    win = 3'd4;
    if (req[0] && rfull)
      win = 3'd0;
    else if (req[1])
      win = 3'd1;
    else if (req[0])
      win = 3'd0;
    else if (req[2] && (!rr || !req[3]))
      win = 3'd2;
    else if (req[3])
      win = 3'd3;
    else
      win = 3'd4;
  end

  always_comb begin
    st_n    = st;
    gnt_n   = gnt;
    owner_n = owner;
    hc_n    = hc;
    tc_n    = tc;
    rr_n    = rr;
    if (tick) begin
      unique case (st)
        IDLE: begin
          if (|req) begin
            st_n    = GRANT;
            gnt_n   = 5'b00001 << win;
            owner_n = win;
            hc_n    = 6'd0;
            if (win == 3'd2)
              rr_n = 1'b1;
            else if (win == 3'd3)
              rr_n = 1'b0;
          end
        end
        GRANT: begin
          if (cyc_done) begin
            hc_n = (hc == 6'd63) ? hc : hc + 6'd1;
            if (!held || (limit && others)) begin
              st_n    = TURN;
              gnt_n   = 5'b00000;
              owner_n = 3'd7;
              tc_n    = 2'(TURN_TICKS - 1);
            end
          end
        end
        TURN: begin
          if (tc == 2'd0)
            st_n = IDLE;
          else
            tc_n = tc - 2'd1;
        end
        default: begin
          st_n    = IDLE;
          gnt_n   = 5'b00000;
          owner_n = 3'd7;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      st    <= IDLE;
      clk_q <= 1'b0;
      gnt   <= 5'b00000;
      owner <= 3'd7;
      hc    <= 6'd0;
      tc    <= 2'd0;
      rr    <= 1'b0;
    end else begin
      st    <= st_n;
      clk_q <= clk;
      gnt   <= gnt_n;
      owner <= owner_n;
      hc    <= hc_n;
      tc    <= tc_n;
      rr    <= rr_n;
    end
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Memory-bus arbiter for the Jaguar system bus. It shares the single DRAM/bus interface among five requesters: DRAM refresh, object processor, blitter, GPU and CPU. Grants are fixed-priority, with a rotating slot between blitter and GPU, an urgent-refresh override and a tenure limit. It consumes `refreq`/`full` from the refresh counter in the misc block and returns the grant and acknowledge that block uses to decrement its pending count.

## Interface
- `TURN_TICKS`, default 1: turnaround ticks with no grant after each tenure (legal 1..3).
- `HOLD_MAX`, default 16: completed bus cycles after which a tenure may be preempted (legal 1..63).
- `sys_clk` in 1: system clock.
- `resetl` in 1: reset, synchronous, active-low.
- `clk` in 1: Jaguar bus clock, sampled on sys_clk. A "tick" is a sys_clk cycle where `clk`=1 and the previous sample was 0. All state advances only on ticks.
- `req[4:0]` in 5: requests. 0 = refresh (`refreq`), 1 = object proc, 2 = blitter, 3 = GPU, 4 = CPU. Held high until served.
- `rfull` in 1: refresh backlog full (misc `rc[3]`); promotes req[0] to top priority.
- `cyc_done` in 1: current bus cycle completes this tick.
- `gnt[4:0]` out 5: one-hot grant, registered.
- `ack[4:0]` out 5: `gnt & {5{cyc_done}}`. Combinational; valid on tick cycles only.
- `owner[2:0]` out 3: index of the current grantee; 7 when no grant is active.
- `busy` out 1: high while in GRANT.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: exactly one `gnt` bit high.
  - TURN: no grant; a turnaround counter `tc` runs.
- Priority order:
  1. `req[0] & rfull`
  2. `req[1]`
  3. `req[0]`
  4. the preferred one of {2,3}, then the other
  5. `req[4]`
- Rotation pointer `rr` (1 bit, reset 0 = blitter preferred) selects which of {2,3} is preferred. It flips to the non-granted one whenever 2 or 3 is granted. Grants to other requesters leave it unchanged.
- IDLE, on a tick with any `req` high: latch the winner, set `gnt`/`owner`, clear `hc`, go to GRANT.
- GRANT, on a tick with `cyc_done`=1:
  - `hc` increments, saturating at 63.
  - End the tenure if `req[owner]`=0, or if (`hc`+1 ≥ `HOLD_MAX` and any other `req` bit is high).
  - Ending a tenure means: `gnt`←0, `owner`←7, load `tc`←`TURN_TICKS`−1, go to TURN.
  - Otherwise stay in GRANT.
- GRANT, on a tick with `cyc_done`=0: no change. A grant is never withdrawn mid-cycle, even if the requester drops `req`.
- TURN, on a tick: if `tc`=0 go to IDLE, otherwise `tc`←`tc`−1. Requests are ignored in TURN.
- Urgent refresh does not preempt an active tenure. It only wins the next arbitration.
- Reset (`resetl`=0 at a sys_clk edge, tick or not):
  - state←IDLE, `gnt`←0, `owner`←7, `busy`←0, `hc`←0, `tc`←0, `rr`←0.
  - `ack` is therefore 0.
  - The clock-edge history register also resets to 0, so a `clk` that is high on the first cycle after reset counts as a tick.
- Reset mid-tenure drops the grant on the next sys_clk edge. No turnaround is inserted after reset.

## Timing
- Grant latency: a request seen at IDLE tick N gives `gnt` high from the sys_clk cycle after tick N.
- Back-to-back spacing:
  - Tenure ends at tick N.
  - TURN occupies ticks N+1 … N+`TURN_TICKS`.
  - IDLE arbitrates at tick N+`TURN_TICKS`+1.
  - With `TURN_TICKS`=1, the next grant is visible after tick N+2.
- `ack[i]` is high only in the sys_clk cycle of a tick where `gnt[i]` and `cyc_done` are both high. Misc decrements its refresh count on `ack[0]`.
- Between ticks all outputs hold. No output changes on non-tick cycles, except during reset.
- `hc` saturation: `HOLD_MAX` ≤ 63, so the preempt compare is always reachable.
- `rfull` and `req` are sampled only at IDLE ticks, for winner selection, and at GRANT ticks, for release and preemption.

## Test plan
- Reset / single request:
  - Hold `resetl`=0 → `gnt`=0, `owner`=7, `busy`=0.
  - Release, then assert `req`=5'b10000 → `gnt`=5'b10000 after the first tick.
  - Drop `req` with `cyc_done` at tick 3 → `gnt`=0 after tick 3; IDLE after tick 4 (`TURN_TICKS`=1).
- Priority:
  - `req`=5'b11111, `rfull`=0 → grant order 1, 0, 2, 3, 4, with each owner releasing after one `cyc_done`.
  - Repeat with `rfull`=1 → first grant goes to 0.
- Rotation:
  - `req`=5'b01100 held, with single-cycle tenures by dropping and re-raising → grants alternate 2, 3, 2, 3.
  - `rr` persists across an intervening grant to 1.
- Tenure limit:
  - `HOLD_MAX`=4, CPU holds `req[4]`, `cyc_done` every tick, `req[2]` raised at tick 1 → CPU releases after its 4th `cyc_done`, blitter is granted `TURN_TICKS`+1 ticks later.
  - With no other request, CPU keeps the grant indefinitely.
- No mid-cycle release: owner drops `req` while `cyc_done`=0 for 5 ticks → `gnt` stays high until the `cyc_done` tick; `ack[owner]` pulses exactly once.
- Reset mid-tenure / tick gating:
  - Assert `resetl`=0 during GRANT on a non-tick cycle → `gnt`=0 next cycle.
  - With `clk` held static and `req` high, no grant is ever issued.
